// File: rtl/int_sequencer.sv
// Interrupt entry/exit sequencer: stacks PC/SR and vectors on entry, pops SR/PC on RTI.
// Define INT_SEQ_TIMEOUT_EN to abort a bus access that waits too long (pulses ERR).
module int_sequencer #(
    parameter int              DW          = 16,
    parameter int              STACK_STEP  = 2,
    parameter logic [DW-1:0]   SR_CLR_MASK = 16'h0008
`ifdef INT_SEQ_TIMEOUT_EN
    ,parameter int             TIMEOUT_CYC = 15
`endif
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          REQ,
    input  logic [DW-1:0] ADDRInt,
    input  logic          INSTR_END,
    input  logic          RTI_EXEC,
    input  logic [DW-1:0] PC_IN,
    input  logic [DW-1:0] SR_IN,
    input  logic [DW-1:0] SP_IN,
    input  logic [DW-1:0] MEM_RDATA,
    input  logic          MEM_ACK,
    output logic [DW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_WDATA,
    output logic          MEM_WE,
    output logic          MEM_RE,
    output logic [DW-1:0] PC_OUT,
    output logic [DW-1:0] SR_OUT,
    output logic [DW-1:0] SP_OUT,
    output logic          PC_LOAD,
    output logic          SR_LOAD,
    output logic          SP_LOAD,
    output logic          INTA,
    output logic          RTI_DONE,
    output logic          BUSY,
    output logic          ERR
);

    localparam logic [DW-1:0] STEP = DW'(STACK_STEP);

    typedef enum logic [2:0] {
        IDLE, PUSH_PC, PUSH_SR, FETCH_VEC, LOAD_ENT, POP_SR, POP_PC, LOAD_RET
    } state_t;

    state_t        state_q, state_nxt;
    logic [DW-1:0] sp_q, pc_q, sr_q, vec_q;
    logic          accept_rti, accept_int;

    assign accept_rti = INSTR_END & RTI_EXEC;
    assign accept_int = INSTR_END & REQ & ~RTI_EXEC;

`ifdef INT_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q;
    logic          err_q, bus_st, tmo;

    assign bus_st = (state_q == PUSH_PC) || (state_q == PUSH_SR) || (state_q == FETCH_VEC) ||
                    (state_q == POP_SR)  || (state_q == POP_PC);
    assign tmo    = bus_st && !MEM_ACK && (cnt_q == CW'(TIMEOUT_CYC - 1));
    assign ERR    = err_q;

    // Wait counter restarts whenever the state changes, so each access gets the full budget.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= tmo;
            cnt_q <= (state_nxt != state_q || !bus_st) ? '0 : cnt_q + CW'(1);
        end
    end
`else
    assign ERR = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state_q <= IDLE;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:      if (accept_rti)      state_nxt = POP_SR;
                       else if (accept_int) state_nxt = PUSH_PC;
            PUSH_PC:   if (MEM_ACK) state_nxt = PUSH_SR;
            PUSH_SR:   if (MEM_ACK) state_nxt = FETCH_VEC;
            FETCH_VEC: if (MEM_ACK) state_nxt = LOAD_ENT;
            LOAD_ENT:  state_nxt = IDLE;
            POP_SR:    if (MEM_ACK) state_nxt = POP_PC;
            POP_PC:    if (MEM_ACK) state_nxt = LOAD_RET;
            LOAD_RET:  state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
`ifdef INT_SEQ_TIMEOUT_EN
        if (tmo) state_nxt = IDLE;
`endif
    end

    // SP is pre-decremented on entry so the push address is stable from PUSH_PC entry.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sp_q  <= '0;
            pc_q  <= '0;
            sr_q  <= '0;
            vec_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_rti) begin
                        sp_q <= SP_IN;
                    end else if (accept_int) begin
                        sp_q  <= SP_IN - STEP;
                        pc_q  <= PC_IN;
                        sr_q  <= SR_IN;
                        vec_q <= ADDRInt;
                    end
                end
                PUSH_PC:   if (MEM_ACK) sp_q <= sp_q - STEP;
                FETCH_VEC: if (MEM_ACK) pc_q <= MEM_RDATA;
                POP_SR: if (MEM_ACK) begin
                    sr_q <= MEM_RDATA;
                    sp_q <= sp_q + STEP;
                end
                POP_PC: if (MEM_ACK) begin
                    pc_q <= MEM_RDATA;
                    sp_q <= sp_q + STEP;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        MEM_ADDR  = '0;
        MEM_WDATA = '0;
        MEM_WE    = 1'b0;
        MEM_RE    = 1'b0;
        PC_OUT    = '0;
        SR_OUT    = '0;
        SP_OUT    = '0;
        PC_LOAD   = 1'b0;
        SR_LOAD   = 1'b0;
        SP_LOAD   = 1'b0;
        INTA      = 1'b0;
        RTI_DONE  = 1'b0;
        case (state_q)
            PUSH_PC: begin
                MEM_WE    = 1'b1;
                MEM_ADDR  = sp_q;
                MEM_WDATA = pc_q;
            end
            PUSH_SR: begin
                MEM_WE    = 1'b1;
                MEM_ADDR  = sp_q;
                MEM_WDATA = sr_q;
            end
            FETCH_VEC: begin
                MEM_RE   = 1'b1;
                MEM_ADDR = vec_q;
            end
            LOAD_ENT: begin
                PC_OUT  = pc_q;
                SR_OUT  = sr_q & ~SR_CLR_MASK;
                SP_OUT  = sp_q;
                PC_LOAD = 1'b1;
                SR_LOAD = 1'b1;
                SP_LOAD = 1'b1;
                INTA    = 1'b1;
            end
            POP_SR, POP_PC: begin
                MEM_RE   = 1'b1;
                MEM_ADDR = sp_q;
            end
            LOAD_RET: begin
                PC_OUT   = pc_q;
                SR_OUT   = sr_q;
                SP_OUT   = sp_q;
                PC_LOAD  = 1'b1;
                SR_LOAD  = 1'b1;
                SP_LOAD  = 1'b1;
                RTI_DONE = 1'b1;
            end
            default: ;
        endcase
    end

    // Stall already in the accepting cycle so the CPU never starts the next instruction.
    assign BUSY = RESET & ((state_q != IDLE) | (INSTR_END & (REQ | RTI_EXEC)));

endmodule
